sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 52 +++++
 rtl/sync_fifo_param.sv | 112 +++++++++++
 tb/tb_sync_fifo_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO.
// Holds the default depth, the level-width helper and the parameter range
// check macro that is expanded inside generate scope by the FIFO top.
package sync_fifo_pkg;

  localparam int DEFAULT_DEPTH_POWER = 2;
  localparam int DEPTH               = 1 << DEFAULT_DEPTH_POWER;
  localparam int MIN_DEPTH_POWER     = 1;
  localparam int MAX_DEPTH_POWER     = 12;

  // Bits needed to hold a fill level of 0..depth inclusive. A depth of 2**n
  // needs n+1 bits; depth 0 is clamped so the result is never zero-width.
  function automatic int level_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// Elaboration-time range check; expands to a generate-if that stops
// elaboration when the value falls outside [lo, hi].
`define SYNC_FIFO_CHECK_RANGE(val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin \
    $error("sync_fifo_param: parameter out of range"); \
  end

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: one write port, one read port.
// Latency: write 1 cycle; read 1 cycle when REG_RD=1, combinational when REG_RD=0.
// Backpressure: none; the caller only asserts we_i/re_i for accepted operations.
// Ports: clk_i/rst_i clock and sync reset (clears only the registered read data),
//        we_i/waddr_i/wdata_i write port, re_i/raddr_i/rdata_o read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter bit REG_RD     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  // Storage is never reset; stale words are unreachable once pointers clear.
  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_RD) begin : g_reg_rd
      // Output register holds its value until the next accepted pop.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_o <= '0;
        end else if (re_i) begin
          rdata_o <= mem_q[raddr_i];
        end
      end
    end else begin : g_async_rd
      // Head word is presented directly; rst_i/re_i have no role here.
      logic unused_rd_ctl;
      assign unused_rd_ctl = rst_i ^ re_i;
      assign rdata_o       = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO using all 2**DEPTH_POWER entries.
// Latency: flags/level update on the edge after an accepted op; dout 1 cycle (std) or 0 (FWFT).
// Backpressure: wrdy_o low when full drops writes; rrdy_o low when empty ignores pops.
// Ports: clk_i, rst_i (sync, active-high); we_i/din_i/wrdy_o write side;
//        re_i/dout_o/rrdy_o read side; level_o, almost_full_o, almost_empty_o status.
// Optional: define SYNC_FIFO_ERR_FLAGS_EN to add err_clr_i, overflow_o, underflow_o.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_POWER = 2,
  parameter int FWFT        = 0,
  parameter int AFULL_LVL   = (1 << DEPTH_POWER) - 1,
  parameter int AEMPTY_LVL  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  wrdy_o,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  rrdy_o,
  output logic [level_width(1 << DEPTH_POWER)-1:0] level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr_i,
  output logic                  overflow_o,
  output logic                  underflow_o
`endif
);

  localparam int FIFO_DEPTH = 1 << DEPTH_POWER;
  localparam int PW         = DEPTH_POWER + 1;

  `SYNC_FIFO_CHECK_RANGE(DEPTH_POWER, MIN_DEPTH_POWER, MAX_DEPTH_POWER)
  `SYNC_FIFO_CHECK_RANGE(AFULL_LVL, 0, FIFO_DEPTH)
  `SYNC_FIFO_CHECK_RANGE(AEMPTY_LVL, 0, FIFO_DEPTH)

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] AFULL_V  = AFULL_LVL[PW-1:0];
  localparam logic [PW-1:0] AEMPTY_V = AEMPTY_LVL[PW-1:0];

  // Extra MSB on each pointer is the wrap bit distinguishing full from empty.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full;
  logic          wr_acc, rd_acc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  // Requests in a reset cycle are ignored, including the memory write.
  assign wr_acc = we_i & ~full & ~rst_i;
  assign rd_acc = re_i & ~empty & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Modular difference gives the true count even after the pointers wrap.
  assign level_o        = wr_ptr - rd_ptr;
  assign wrdy_o         = ~full;
  assign rrdy_o         = ~empty;
  assign almost_full_o  = (level_o >= AFULL_V);
  assign almost_empty_o = (level_o <= AEMPTY_V);

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_POWER),
    .REG_RD     ((FWFT == 0) ? 1'b1 : 1'b0)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr[PW-2:0]),
    .wdata_i (din_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr[PW-2:0]),
    .rdata_o (dout_o)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; a clear wins over a set arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (err_clr_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we_i && full)  overflow_q  <= 1'b1;
      if (re_i && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: a standard-mode FIFO (u_std) and an FWFT FIFO
// (u_fwft), both 4 entries deep with default thresholds (afull at 3, aempty at 1).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       we0, re0, we1, re1;
  logic [7:0] din0, din1;
  logic       wrdy0, rrdy0, af0, ae0, wrdy1, rrdy1, af1, ae1;
  logic [7:0] dout0, dout1;
  logic [2:0] lvl0, lvl1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       clr0, clr1, ovf0, unf0, ovf1, unf1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH_POWER(2), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(rst), .we_i(we0), .din_i(din0), .wrdy_o(wrdy0),
    .re_i(re0), .dout_o(dout0), .rrdy_o(rrdy0), .level_o(lvl0),
    .almost_full_o(af0), .almost_empty_o(ae0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr_i(clr0), .overflow_o(ovf0), .underflow_o(unf0)
`endif
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH_POWER(2), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .we_i(we1), .din_i(din1), .wrdy_o(wrdy1),
    .re_i(re1), .dout_o(dout1), .rrdy_o(rrdy1), .level_o(lvl1),
    .almost_full_o(af1), .almost_empty_o(ae1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .err_clr_i(clr1), .overflow_o(ovf1), .underflow_o(unf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fill_v [4];
  logic [7:0] next_wr, next_rd;

  initial begin
    fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
    din0 = 8'h00; din1 = 8'h00;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    clr0 = 1'b0; clr1 = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    check("rst_level", lvl0, 0);
    check("rst_rrdy", rrdy0, 0);
    check("rst_wrdy", wrdy0, 1);
    check("rst_aempty", ae0, 1);
    check("rst_afull", af0, 0);
    check("rst_dout", dout0, 8'h00);
    check("rst_fwft_rrdy", rrdy1, 0);

    // Fill four entries
    we0 = 1'b1;
    din0 = fill_v[0]; tick();
    check("fill1_level", lvl0, 1);
    check("fill1_aempty", ae0, 1);
    din0 = fill_v[1]; tick();
    check("fill2_aempty", ae0, 0);
    check("fill2_afull", af0, 0);
    din0 = fill_v[2]; tick();
    check("fill3_afull", af0, 1);
    check("fill3_wrdy", wrdy0, 1);
    din0 = fill_v[3]; tick();
    check("fill4_level", lvl0, 4);
    check("fill4_wrdy", wrdy0, 0);
    check("fill4_rrdy", rrdy0, 1);
    din0 = 8'h55; tick();
    check("ovf_level", lvl0, 4);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("ovf_flag", ovf0, 1);
`endif
    we0 = 1'b0;

    // Drain in standard mode, data one cycle after each pop
    re0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_dout", dout0, fill_v[i]);
      check("drain_level", lvl0, 3 - i);
    end
    check("drain_rrdy", rrdy0, 0);
    tick();
    check("udf_dout", dout0, 8'h44);
    check("udf_level", lvl0, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("udf_flag", unf0, 1);
    re0 = 1'b0; clr0 = 1'b1; tick(); clr0 = 1'b0;
    check("clr_ovf", ovf0, 0);
    check("clr_unf", unf0, 0);
`endif
    re0 = 1'b0;

    // FWFT: head word visible before any pop
    we1 = 1'b1; din1 = 8'hA5; tick(); we1 = 1'b0;
    check("fwft_dout", dout1, 8'hA5);
    check("fwft_rrdy", rrdy1, 1);
    re1 = 1'b1; tick(); re1 = 1'b0;
    check("fwft_pop_rrdy", rrdy1, 0);
    we1 = 1'b1; din1 = 8'hB6; tick();
    din1 = 8'hC7; tick(); we1 = 1'b0;
    check("fwft_head", dout1, 8'hB6);
    re1 = 1'b1; tick(); re1 = 1'b0;
    check("fwft_next", dout1, 8'hC7);
    check("fwft_level", lvl1, 1);

    // Simultaneous traffic at constant level 2, pointers wrap repeatedly
    we0 = 1'b1;
    din0 = 8'h00; tick();
    din0 = 8'h01; tick();
    check("sim_pre_level", lvl0, 2);
    next_wr = 8'h02; next_rd = 8'h00;
    re0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din0 = next_wr;
      tick();
      check("sim_level", lvl0, 2);
      check("sim_dout", dout0, next_rd);
      next_wr = next_wr + 8'h01;
      next_rd = next_rd + 8'h01;
    end
    re0 = 1'b0;
    din0 = next_wr; tick(); we0 = 1'b0;
    check("pre_rst_level", lvl0, 3);

    // Reset mid-stream; requests during reset are ignored
    rst = 1'b1; we0 = 1'b1; re0 = 1'b1; din0 = 8'h99;
    tick();
    rst = 1'b0; we0 = 1'b0; re0 = 1'b0;
    check("mrst_level", lvl0, 0);
    check("mrst_rrdy", rrdy0, 0);
    check("mrst_dout", dout0, 8'h00);
    we0 = 1'b1; din0 = 8'h5A; tick(); we0 = 1'b0;
    check("post_rst_level", lvl0, 1);
    re0 = 1'b1; tick(); re0 = 1'b0;
    check("post_rst_dout", dout0, 8'h5A);
    check("post_rst_empty", rrdy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
